// File: rtl/laserdrop_pkg.sv
// Shared constants for the laser receive path: framing sequences, lane ids and
// the default inter-byte gap timeout.
package laserdrop_pkg;

    localparam logic [31:0] START_SEQ = 32'hC1C2_C3C4;
    localparam logic [31:0] STOP_SEQ  = 32'h5152_5354;
    localparam logic [31:0] DATA_SEQ  = 32'hD1D2_D3D4;
    localparam logic [31:0] ACK_SEQ   = 32'hC1C2_C3C5;
    localparam logic [31:0] HS_SIGNAL = 32'h5AA5_5AA5;

    typedef enum logic [1:0] {
        SEQ_START = 2'd0,
        SEQ_STOP  = 2'd1,
        SEQ_DATA  = 2'd2,
        SEQ_ACK   = 2'd3
    } seq_id_t;

    localparam int DEFAULT_GAP_TIMEOUT = 1024;

endpackage

// File: rtl/seq_match_lane.sv
// One detector lane: tracks how many bytes of its sequence have been seen and
// emits a registered one-cycle done pulse on completion.
module seq_match_lane #(
    parameter int SEQ_BYTES = 4,
    parameter int BYTE_W    = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          lane_en,
    input  logic                          accept,
    input  logic                          clear,
    input  logic                          abort,
    input  logic [BYTE_W-1:0]             data_in,
    input  logic [SEQ_BYTES*BYTE_W-1:0]   seq_word,
    output logic                          busy,
    output logic                          hit,
    output logic                          done
);

    localparam int PW = $clog2(SEQ_BYTES + 1);

    logic [PW-1:0]     p_q;
    logic              done_q;
    logic [BYTE_W-1:0] exp_byte;
    logic [BYTE_W-1:0] first_byte;
    logic              match;

    always_comb begin
        exp_byte = '0;
        for (int k = 0; k < SEQ_BYTES; k++) begin
            if (p_q == PW'(k)) exp_byte = seq_word[(SEQ_BYTES-1-k)*BYTE_W +: BYTE_W];
        end
    end

    assign first_byte = seq_word[SEQ_BYTES*BYTE_W-1 -: BYTE_W];
    assign match      = (data_in == exp_byte);
    assign hit        = lane_en && accept && !clear && match && (p_q == PW'(SEQ_BYTES-1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= hit;
            if (!lane_en || clear) begin
                p_q <= '0;
            end else if (accept) begin
                // Mismatch restarts on the first byte only; no partial-overlap search.
                if (hit)                          p_q <= '0;
                else if (match)                   p_q <= p_q + PW'(1);
                else if (data_in == first_byte)   p_q <= PW'(1);
                else                              p_q <= '0;
            end else if (abort) begin
                p_q <= '0;
            end
        end
    end

    assign busy = lane_en && (p_q != '0);
    assign done = done_q;

endmodule

// File: rtl/multi_seq_detector.sv
// Multi-lane framing detector: per-sequence lanes plus a shared inter-byte gap
// timer and lowest-index reporting of completed lanes.
module multi_seq_detector
    import laserdrop_pkg::*;
#(
    parameter int NUM_SEQ     = 8,
    parameter int SEQ_BYTES   = 4,
    parameter int BYTE_W      = 8,
    parameter int GAP_TIMEOUT = DEFAULT_GAP_TIMEOUT,
    localparam int IW         = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      en,
    input  logic                                      clear,
    input  logic                                      data_valid,
    input  logic [BYTE_W-1:0]                         data_in,
    input  logic [NUM_SEQ-1:0][SEQ_BYTES*BYTE_W-1:0]  seq,
    input  logic [NUM_SEQ-1:0]                        seq_en,
    output logic [NUM_SEQ-1:0]                        saw_seq,
    output logic                                      saw_any,
    output logic [IW-1:0]                             saw_index,
    output logic                                      in_progress
);

    localparam int TW = (GAP_TIMEOUT == 0) ? 1 : $clog2(GAP_TIMEOUT + 1);

    logic [TW-1:0]      timer_q;
    logic [NUM_SEQ-1:0] busy;
    logic [NUM_SEQ-1:0] hit;
    logic               accept;
    logic               counting;
    logic               timeout;
    logic               any_q;
    logic [IW-1:0]      idx_q;
    logic [IW-1:0]      idx_d;

    assign accept      = data_valid && en && !clear;
    assign in_progress = |busy;
    assign counting    = in_progress && en && !data_valid && !clear;
    assign timeout     = (GAP_TIMEOUT != 0) && counting && (timer_q == TW'(GAP_TIMEOUT - 1));

    for (genvar i = 0; i < NUM_SEQ; i++) begin : g_lane
        seq_match_lane #(
            .SEQ_BYTES (SEQ_BYTES),
            .BYTE_W    (BYTE_W)
        ) u_lane (
            .clock    (clock),
            .reset    (reset),
            .lane_en  (seq_en[i]),
            .accept   (accept),
            .clear    (clear),
            .abort    (timeout),
            .data_in  (data_in),
            .seq_word (seq[i]),
            .busy     (busy[i]),
            .hit      (hit[i]),
            .done     (saw_seq[i])
        );
    end

    always_comb begin
        idx_d = '0;
        for (int i = NUM_SEQ - 1; i >= 0; i--) begin
            if (hit[i]) idx_d = IW'(i);
        end
    end

    // en low freezes the timer along with lane progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else if (clear || accept || !in_progress || timeout) begin
            timer_q <= '0;
        end else if (counting && (GAP_TIMEOUT != 0)) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            any_q <= 1'b0;
            idx_q <= '0;
        end else begin
            any_q <= |hit;
            idx_q <= idx_d;
        end
    end

    assign saw_any   = any_q;
    assign saw_index = idx_q;

endmodule

// File: tb/tb_multi_seq_detector.sv
// Scoreboard bench for multi_seq_detector: expected pulses are queued as bytes
// are driven and checked by a monitor whenever the DUT reports a completion.
module tb_multi_seq_detector;
    import laserdrop_pkg::*;

    localparam int NS = 4;
    localparam int SB = 4;
    localparam int BW = 8;
    localparam int GT = 16;

    logic                        clock = 1'b0;
    logic                        reset = 1'b0;
    logic                        en = 1'b1;
    logic                        clear = 1'b0;
    logic                        data_valid = 1'b0;
    logic [BW-1:0]               data_in = '0;
    logic [NS-1:0][SB*BW-1:0]    seq;
    logic [NS-1:0]               seq_en = 4'b1111;
    logic [NS-1:0]               saw_seq;
    logic                        saw_any;
    logic [1:0]                  saw_index;
    logic                        in_progress;

    typedef struct {
        logic [NS-1:0] vec;
        logic [1:0]    idx;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    multi_seq_detector #(
        .NUM_SEQ(NS), .SEQ_BYTES(SB), .BYTE_W(BW), .GAP_TIMEOUT(GT)
    ) dut (
        .clock(clock), .reset(reset), .en(en), .clear(clear),
        .data_valid(data_valid), .data_in(data_in), .seq(seq), .seq_en(seq_en),
        .saw_seq(saw_seq), .saw_any(saw_any), .saw_index(saw_index),
        .in_progress(in_progress)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        exp_t e;
        if (saw_seq !== '0 || saw_any !== 1'b0) begin
            if (exp_q.size() == 0) begin
                tests_run++; tests_failed++;
                $display("FAIL unexpected_pulse cyc=%0d saw_seq=%b saw_any=%b saw_index=%0d, required no pulse",
                         cyc, saw_seq, saw_any, saw_index);
            end else begin
                e = exp_q.pop_front();
                tests_run++;
                if (saw_seq !== e.vec) begin
                    tests_failed++;
                    $display("FAIL saw_seq cyc=%0d got=%b required=%b", cyc, saw_seq, e.vec);
                end
                tests_run++;
                if (saw_any !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL saw_any cyc=%0d got=%b required=1", cyc, saw_any);
                end
                tests_run++;
                if (saw_index !== e.idx) begin
                    tests_failed++;
                    $display("FAIL saw_index cyc=%0d got=%0d required=%0d", cyc, saw_index, e.idx);
                end
                tests_run++;
                if (cyc !== e.cyc) begin
                    tests_failed++;
                    $display("FAIL pulse_cycle got=%0d required=%0d", cyc, e.cyc);
                end
            end
        end else if (saw_index !== 2'd0) begin
            tests_run++; tests_failed++;
            $display("FAIL idle_index cyc=%0d got=%0d required=0", cyc, saw_index);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [BW-1:0] b);
        data_in    = b;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic expect_pulse(input logic [NS-1:0] vec, input logic [1:0] idx);
        exp_t e;
        e.vec = vec; e.idx = idx; e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < SB; i++) begin
            strobe(t[31-8*i -: 8]);
            idle(gap);
        end
    endtask

    task automatic end_check(input string name);
        idle(3);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s missing_pulses got=0 required=%0d", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_prog(input string name, input logic req);
        tests_run++;
        if (in_progress !== req) begin
            tests_failed++;
            $display("FAIL %s in_progress got=%b required=%b", name, in_progress, req);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        tests_run++;
        if (saw_seq !== '0 || saw_any !== 1'b0 || saw_index !== 2'd0 || in_progress !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s outputs got=%b/%b/%0d/%b required=0/0/0/0",
                     name, saw_seq, saw_any, saw_index, in_progress);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        check_zero_outputs("reset");
        idle(2);
        reset = 1'b1;
        idle(2);
        check_zero_outputs("post_reset");
    endtask

    task automatic test_single_match();
        strobe(8'hC1); idle(3);
        strobe(8'hC2); idle(3);
        strobe(8'hC3); idle(3);
        check_prog("single_mid", 1'b1);
        expect_pulse(4'b0001, 2'd0);
        strobe(8'hC4);
        check_prog("single_done", 1'b0);
        idle(3);
        end_check("single_match");
    endtask

    task automatic test_restart();
        strobe(8'hC1); strobe(8'hC2); strobe(8'hC3);
        expect_pulse(4'b1000, 2'd3);
        strobe(8'hC5);
        check_prog("ack_done_lane0_cleared", 1'b0);
        end_check("ack_match");
        strobe(8'hC1); strobe(8'hC1); strobe(8'hC2); strobe(8'hC3);
        expect_pulse(4'b0001, 2'd0);
        strobe(8'hC4);
        end_check("restart");
    endtask

    task automatic test_gap_timeout();
        strobe(8'hC1); strobe(8'hC2);
        idle(GT - 1);
        check_prog("gap_before_timeout", 1'b1);
        idle(1);
        check_prog("gap_at_timeout", 1'b0);
        strobe(8'hC3); strobe(8'hC4);
        end_check("gap_timeout");
        strobe(8'hC1); strobe(8'hC2);
        idle(GT - 1);
        strobe(8'hC3);
        expect_pulse(4'b0001, 2'd0);
        strobe(8'hC4);
        end_check("gap_just_inside");
    endtask

    task automatic test_reset_mid_match();
        strobe(8'hD1); strobe(8'hD2);
        check_prog("data_before_reset", 1'b1);
        reset = 1'b0;
        #2;
        check_zero_outputs("reset_mid_match");
        tick();
        reset = 1'b1;
        strobe(8'hD3); strobe(8'hD4);
        end_check("reset_mid_match");
    endtask

    task automatic test_en_and_clear();
        strobe(8'hD1);
        en = 1'b0;
        strobe(8'hD2);
        en = 1'b1;
        strobe(8'hD2); strobe(8'hD3);
        expect_pulse(4'b0100, 2'd2);
        strobe(8'hD4);
        end_check("en_ignore");
        strobe(8'hD1); strobe(8'hD2); strobe(8'hD3);
        clear = 1'b1;
        strobe(8'hD4);
        clear = 1'b0;
        check_prog("clear_with_final", 1'b0);
        end_check("clear_with_final");
    endtask

    task automatic test_mask_and_simultaneous();
        seq_en = 4'b1110;
        send_word(START_SEQ, 0);
        end_check("lane0_masked");
        seq_en = 4'b1111;
        seq[SEQ_START] = STOP_SEQ;
        idle(1);
        strobe(8'h51); strobe(8'h52); strobe(8'h53);
        expect_pulse(4'b0011, 2'd0);
        strobe(8'h54);
        end_check("simultaneous");
    endtask

    initial begin
        seq[SEQ_START] = START_SEQ;
        seq[SEQ_STOP]  = STOP_SEQ;
        seq[SEQ_DATA]  = DATA_SEQ;
        seq[SEQ_ACK]   = ACK_SEQ;
        test_reset();
        test_single_match();
        test_restart();
        test_gap_timeout();
        test_reset_mid_match();
        test_en_and_clear();
        test_mask_and_simultaneous();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
